// File: rtl/tmcu_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tmcu_gpio_irq
// Purpose  : GPIO input interrupt controller with an APB register interface.
//            Pins are double-flop synchronised (RAW) and then debounced on a
//            prescaled tick (FILT). Rising and falling edges of FILT set
//            sticky STATUS bits, which are cleared by writing 1 (W1C).
//            irq is the OR of the STATUS bits that are enabled in IE.
// Ports    : clk, rst_n               - clock, async active-low reset
//            psel/penable/pwrite      - APB control
//            paddr[31:0], pwdata[31:0] - APB address/write data
//            prdata[31:0]             - registered APB read data
//            pready                   - always 1, no wait states
//            gpio_in[NPINS-1:0]       - asynchronous pin levels
//            irq                      - level interrupt
// Map      : 0x00 RAW, 0x04 FILT, 0x08 IE, 0x0C RISE_EN, 0x10 FALL_EN,
//            0x14 STATUS (W1C), 0x18 PRESCALE[15:0], 0x1C DBLEN[3:0]
// Revision : 1.0 - initial release
// ============================================================================
module tmcu_gpio_irq #(
  parameter int NPINS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [31:0]      paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  input  logic [NPINS-1:0] gpio_in,
  output logic             irq
);

  localparam logic [4:0] c_ADDR_RAW      = 5'h00;
  localparam logic [4:0] c_ADDR_FILT     = 5'h04;
  localparam logic [4:0] c_ADDR_IE       = 5'h08;
  localparam logic [4:0] c_ADDR_RISE_EN  = 5'h0C;
  localparam logic [4:0] c_ADDR_FALL_EN  = 5'h10;
  localparam logic [4:0] c_ADDR_STATUS   = 5'h14;
  localparam logic [4:0] c_ADDR_PRESCALE = 5'h18;
  localparam logic [4:0] c_ADDR_DBLEN    = 5'h1C;

  logic [NPINS-1:0] r_sync1;
  logic [NPINS-1:0] r_raw;
  logic [NPINS-1:0] r_filt;
  logic [NPINS-1:0] r_filt_q;
  logic [NPINS-1:0] r_ie;
  logic [NPINS-1:0] r_rise_en;
  logic [NPINS-1:0] r_fall_en;
  logic [NPINS-1:0] r_status;
  logic [3:0]       r_dbcnt [NPINS];
  logic [3:0]       w_dbinc [NPINS];
  logic [15:0]      r_pre_cnt;
  logic [15:0]      r_prescale;
  logic [3:0]       r_dblen;
  logic [31:0]      r_prdata;
  logic [31:0]      w_rdata;

  logic             w_wr;
  logic             w_rd;
  logic             w_tick;
  logic [NPINS-1:0] w_set;
  logic [NPINS-1:0] w_clr;
  logic             w_unused_bits;

  assign w_wr   = psel & penable & pwrite;
  assign w_rd   = psel & ~pwrite;
  assign w_tick = (r_pre_cnt == r_prescale);
  assign pready = 1'b1;
  assign prdata = r_prdata;

  // Only the low five address bits and the used data bits matter.
  assign w_unused_bits = ^{paddr[31:5], pwdata};

  // Edge events come from FILT and its one-cycle-delayed copy.
  assign w_set = ( r_filt & ~r_filt_q & r_rise_en)
               | (~r_filt &  r_filt_q & r_fall_en);
  assign w_clr = (w_wr && paddr[4:0] == c_ADDR_STATUS) ? pwdata[NPINS-1:0] : '0;

  // Purely a function of flops, so APB activity never glitches irq.
  assign irq = |(r_status & r_ie);

  always_comb begin
    for (int i = 0; i < NPINS; i++) begin
      w_dbinc[i] = r_dbcnt[i] + 4'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (paddr[4:0])
      c_ADDR_RAW:      w_rdata = 32'(r_raw);
      c_ADDR_FILT:     w_rdata = 32'(r_filt);
      c_ADDR_IE:       w_rdata = 32'(r_ie);
      c_ADDR_RISE_EN:  w_rdata = 32'(r_rise_en);
      c_ADDR_FALL_EN:  w_rdata = 32'(r_fall_en);
      c_ADDR_STATUS:   w_rdata = 32'(r_status);
      c_ADDR_PRESCALE: w_rdata = 32'(r_prescale);
      c_ADDR_DBLEN:    w_rdata = 32'(r_dblen);
      default:         w_rdata = '0;
    endcase
  end

  // Synchroniser, edge-detect history and prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_raw     <= '0;
      r_filt_q  <= '0;
      r_pre_cnt <= '0;
    end else begin
      r_sync1  <= gpio_in;
      r_raw    <= r_sync1;
      r_filt_q <= r_filt;
      if (w_wr && paddr[4:0] == c_ADDR_PRESCALE) begin
        r_pre_cnt <= '0;
      end else if (w_tick) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + 16'd1;
      end
    end
  end

  // Debounce: a pin must disagree with FILT on DBLEN consecutive ticks
  // before FILT follows it. DBLEN == 0 bypasses the filter entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
      for (int i = 0; i < NPINS; i++) begin
        r_dbcnt[i] <= '0;
      end
    end else begin
      if (r_dblen == 4'd0) begin
        r_filt <= r_raw;
        for (int i = 0; i < NPINS; i++) begin
          r_dbcnt[i] <= '0;
        end
      end else if (w_tick) begin
        for (int i = 0; i < NPINS; i++) begin
          if (r_raw[i] != r_filt[i]) begin
            if (w_dbinc[i] == r_dblen) begin
              r_filt[i]  <= r_raw[i];
              r_dbcnt[i] <= '0;
            end else begin
              r_dbcnt[i] <= w_dbinc[i];
            end
          end else begin
            r_dbcnt[i] <= '0;
          end
        end
      end
      // A new debounce length restarts every pin's count.
      if (w_wr && paddr[4:0] == c_ADDR_DBLEN) begin
        for (int i = 0; i < NPINS; i++) begin
          r_dbcnt[i] <= '0;
        end
      end
    end
  end

  // Programmable registers, STATUS and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ie       <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_status   <= '0;
      r_prescale <= '0;
      r_dblen    <= '0;
      r_prdata   <= '0;
    end else begin
      if (w_wr) begin
        case (paddr[4:0])
          c_ADDR_IE:       r_ie       <= pwdata[NPINS-1:0];
          c_ADDR_RISE_EN:  r_rise_en  <= pwdata[NPINS-1:0];
          c_ADDR_FALL_EN:  r_fall_en  <= pwdata[NPINS-1:0];
          c_ADDR_PRESCALE: r_prescale <= pwdata[15:0];
          c_ADDR_DBLEN:    r_dblen    <= pwdata[3:0];
          default:         ;
        endcase
      end
      // Set is applied after clear so a simultaneous event is not lost.
      r_status <= (r_status & ~w_clr) | w_set;
      if (w_rd) begin
        r_prdata <= w_rdata;
      end
    end
  end

endmodule
`default_nettype wire
